// File: rtl/width_conv_pkg.sv
// Shared definitions for the 8-to-16 packer and 16-to-8 unpacker: state encoding,
// nominal widths and the word half-select helper.
package width_conv_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } conv_state_e;

  function automatic logic [BYTE_W-1:0] half_select(input logic [WORD_W-1:0] word,
                                                    input logic upper);
    return upper ? word[WORD_W-1:BYTE_W] : word[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/width_16to8_if.sv
// Word-in / byte-out valid/ready bus for the width unpacker.
// master drives words and byte backpressure; slave is the unpacker itself.
interface width_16to8_if #(
  parameter int unsigned OUT_W = 8
);

  logic               valid_in;
  logic [2*OUT_W-1:0] data_in;
  logic               ready_in;
  logic               valid_out;
  logic [OUT_W-1:0]   data_out;
  logic               ready_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );

endinterface

// File: rtl/width_16to8.sv
// Width unpacker: each 2*OUT_W word leaves as two OUT_W bytes from registered state.
// Define WIDTH_16TO8_PIPE_EN to accept the next word during the second byte's transfer.
module width_16to8
  import width_conv_pkg::*;
#(
  parameter int unsigned OUT_W     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  width_16to8_if.slave bus
);

  localparam int unsigned IN_W = 2 * OUT_W;

  conv_state_e       state_q;
  logic [IN_W-1:0]   hold_q;
  logic              valid_q;
  logic [OUT_W-1:0]  data_q;

  logic              accept;
  logic              xfer;
  logic [OUT_W-1:0]  in_first;
  logic [OUT_W-1:0]  hold_second;

  if (IN_W == WORD_W) begin : g_pkg_mux
    assign in_first    = half_select(bus.data_in, MSB_FIRST);
    assign hold_second = half_select(hold_q, !MSB_FIRST);
  end else begin : g_gen_mux
    assign in_first    = MSB_FIRST ? bus.data_in[IN_W-1:OUT_W] : bus.data_in[OUT_W-1:0];
    assign hold_second = MSB_FIRST ? hold_q[OUT_W-1:0] : hold_q[IN_W-1:OUT_W];
  end

`ifdef WIDTH_16TO8_PIPE_EN
  assign bus.ready_in = rst_n && ((state_q == IDLE) || ((state_q == SECOND) && bus.ready_out));
`else
  assign bus.ready_in = rst_n && (state_q == IDLE);
`endif

  assign accept        = bus.valid_in && bus.ready_in;
  assign xfer          = valid_q && bus.ready_out;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            hold_q  <= bus.data_in;
            state_q <= FIRST;
            valid_q <= 1'b1;
            data_q  <= in_first;
          end
        end
        FIRST: begin
          if (xfer) begin
            state_q <= SECOND;
            data_q  <= hold_second;
          end
        end
        SECOND: begin
          // An accept here only happens in pipelined mode and always coincides with xfer.
          if (accept) begin
            hold_q  <= bus.data_in;
            state_q <= FIRST;
            valid_q <= 1'b1;
            data_q  <= in_first;
          end else if (xfer) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_width_16to8.sv
// Self-checking bench for width_16to8: an MSB-first and an LSB-first instance share stimulus;
// a byte-queue reference model and a word reassembler check ordering, stalls and reset.
module tb_width_16to8;

`ifdef WIDTH_16TO8_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  width_16to8_if #(.OUT_W(8)) ia ();
  width_16to8_if #(.OUT_W(8)) ib ();

  width_16to8 #(.OUT_W(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  width_16to8 #(.OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] sent[$];
  logic [7:0]  hi_byte;
  bit          have_hi = 1'b0;
  bit          last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    ia.valid_in  = v;
    ib.valid_in  = v;
    ia.data_in   = d;
    ib.data_in   = d;
    ia.ready_out = r;
    ib.ready_out = r;
  endtask

  // Pair MSB-first bytes back into words, acting as the downstream packer.
  task automatic reassemble(input logic [7:0] b);
    logic [31:0] exp;
    if (!have_hi) begin
      hi_byte = b;
      have_hi = 1'b1;
    end else begin
      have_hi = 1'b0;
      exp = (sent.size() != 0) ? {16'h0, sent.pop_front()} : 32'hFFFF_FFFF;
      check("loopback", {16'h0, hi_byte, b}, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic r);
    logic exp_rdy;
    logic [7:0] b;
    @(negedge clk);
    drive(v, d, r);
    #1;
    exp_rdy = (qa.size() == 0) || (PIPE && (qa.size() == 1) && r);
    check("ready_in_msb", {31'h0, ia.ready_in}, {31'h0, exp_rdy});
    check("ready_in_lsb", {31'h0, ib.ready_in}, {31'h0, exp_rdy});
    check("valid_out_msb", {31'h0, ia.valid_out}, {31'h0, qa.size() != 0});
    check("valid_out_lsb", {31'h0, ib.valid_out}, {31'h0, qb.size() != 0});
    if (qa.size() != 0) check("data_out_msb", {24'h0, ia.data_out}, {24'h0, qa[0]});
    if (qb.size() != 0) check("data_out_lsb", {24'h0, ib.data_out}, {24'h0, qb[0]});
    @(posedge clk);
    if ((qa.size() != 0) && r) begin
      b = qa.pop_front();
      void'(qb.pop_front());
      reassemble(b);
    end
    last_acc = v && exp_rdy;
    if (last_acc) begin
      qa.push_back(d[15:8]);
      qa.push_back(d[7:0]);
      qb.push_back(d[7:0]);
      qb.push_back(d[15:8]);
      sent.push_back(d);
    end
  endtask

  // Directed look at the outputs just after the edge a step ended on.
  task automatic peek(input string tag, input bit v, input logic [7:0] a, input logic [7:0] b);
    #2;
    check({tag, "_valid"}, {31'h0, ia.valid_out}, {31'h0, v});
    if (v) begin
      check({tag, "_msb"}, {24'h0, ia.data_out}, {24'h0, a});
      check({tag, "_lsb"}, {24'h0, ib.data_out}, {24'h0, b});
    end
  endtask

  initial begin
    logic        v;
    logic [15:0] d;
    bit          holding;

    drive(1'b0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'h0, ia.valid_out}, 32'h0);
    check("rst_data", {24'h0, ia.data_out}, 32'h0);
    check("rst_ready", {31'h0, ia.ready_in}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic word, MSB first on ia and LSB first on ib.
    step(1'b1, 16'h45AB, 1'b1); peek("w45ab_b1", 1'b1, 8'h45, 8'hAB);
    step(1'b0, 16'h0, 1'b1);    peek("w45ab_b2", 1'b1, 8'hAB, 8'h45);
    step(1'b0, 16'h0, 1'b1);    peek("w45ab_end", 1'b0, 8'h0, 8'h0);
    check("w45ab_ready_back", {31'h0, ia.ready_in}, 32'h1);

    step(1'b1, 16'hF238, 1'b1); peek("wf238_b1", 1'b1, 8'hF2, 8'h38);
    step(1'b0, 16'h0, 1'b1);    peek("wf238_b2", 1'b1, 8'h38, 8'hF2);
    step(1'b0, 16'h0, 1'b1);

    // Stall during the first byte.
    step(1'b1, 16'h1234, 1'b1); peek("stall_b1", 1'b1, 8'h12, 8'h34);
    repeat (3) begin
      step(1'b0, 16'h0, 1'b0);  peek("stall_hold", 1'b1, 8'h12, 8'h34);
    end
    step(1'b0, 16'h0, 1'b1);    peek("stall_b2", 1'b1, 8'h34, 8'h12);
    step(1'b0, 16'h0, 1'b1);    peek("stall_end", 1'b0, 8'h0, 8'h0);

`ifdef WIDTH_16TO8_PIPE_EN
    step(1'b1, 16'h1234, 1'b1); peek("pipe_12", 1'b1, 8'h12, 8'h34);
    step(1'b0, 16'h0, 1'b1);    peek("pipe_34", 1'b1, 8'h34, 8'h12);
    step(1'b1, 16'h5678, 1'b1); peek("pipe_56", 1'b1, 8'h56, 8'h78);
    step(1'b0, 16'h0, 1'b1);    peek("pipe_78", 1'b1, 8'h78, 8'h56);
    step(1'b0, 16'h0, 1'b1);
`endif

    // Reset while the second byte is presented: its byte must never appear.
    step(1'b1, 16'hABCD, 1'b1); peek("rstmid_b1", 1'b1, 8'hAB, 8'hCD);
    step(1'b0, 16'h0, 1'b1);    peek("rstmid_b2", 1'b1, 8'hCD, 8'hAB);
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 16'h1111, 1'b1);
    #1;
    check("rstmid_ready_msb", {31'h0, ia.ready_in}, 32'h0);
    check("rstmid_ready_lsb", {31'h0, ib.ready_in}, 32'h0);
    @(posedge clk);
    #1;
    check("rstmid_valid", {31'h0, ia.valid_out}, 32'h0);
    check("rstmid_data_msb", {24'h0, ia.data_out}, 32'h0);
    check("rstmid_data_lsb", {24'h0, ib.data_out}, 32'h0);
    if (qa.size() != 0) void'(sent.pop_front());
    have_hi = 1'b0;
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 1'b1);
    repeat (2) step(1'b0, 16'h0, 1'b1);

    // Random traffic; an unaccepted word is held until taken.
    holding = 1'b0;
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 600; i++) begin
      if (!holding) begin
        v = ($urandom_range(0, 1) == 1);
        d = 16'($urandom);
      end
      step(v, d, ($urandom_range(0, 3) != 0));
      holding = v && !last_acc;
    end
    for (int i = 0; i < 8; i++) begin
      if (!holding) v = 1'b0;
      step(v, d, 1'b1);
      holding = v && !last_acc;
    end
    check("drain_words", sent.size(), 32'h0);
    check("drain_bytes", qa.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/width_16to8.md
# width_16to8

Width unpacker: accepts 16-bit words on a valid/ready input and emits each as two consecutive 8-bit bytes on a valid/ready output. It is the counterpart of the 8-to-16 packer in the same datapath and drives byte-wide sinks from word-wide sources. Backpressure is honoured on both sides. Output data is always driven from registered state.

## Interface
- `OUT_W`, default 8: output byte width; the input word width is 2*`OUT_W`.
- `MSB_FIRST`, default 1: 1 emits `data_in[15:8]` first; 0 emits `data_in[7:0]` first.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `valid_in`  in  1  upstream word valid.
- `data_in`  in  2*`OUT_W`  upstream word.
- `ready_in`  out  1  block can accept a word this cycle.
- `valid_out`  out  1  `data_out` holds a valid byte.
- `data_out`  out  `OUT_W`  output byte.
- `ready_out`  in  1  downstream accepts the byte this cycle.

## Operation
- States:
  - `IDLE`: holding register empty.
  - `FIRST`: first byte presented.
  - `SECOND`: second byte presented.
- Input accept: `valid_in && ready_in` at a clock edge. On accept, the word is captured into the 16-bit hold register and the state becomes `FIRST`.
- Output transfer: `valid_out && ready_out` at a clock edge.
  - A transfer in `FIRST` moves the state to `SECOND`.
  - A transfer in `SECOND` moves the state to `IDLE`, unless an accept happens in the same cycle (see Configuration), in which case the state becomes `FIRST` with the new word.
- `valid_out` = (state != `IDLE`).
- `data_out` comes from the hold register:
  - In `FIRST`: the high half if `MSB_FIRST`, otherwise the low half.
  - In `SECOND`: the other half.
- Once `valid_out` rises, `valid_out` and `data_out` stay stable until a transfer occurs.
- `valid_in` is ignored while `ready_in` is 0. Upstream holds its word.
- `ready_in` is forced to 0 while `rst_n` is 0.
- Reset values, applied on a clock edge with `rst_n`=0:
  - state = `IDLE`
  - hold register = 0
  - `valid_out` = 0
  - `data_out` = 0
- Reset mid-operation discards the held word and any byte not yet sent. Nothing is emitted afterwards.

## Timing
- Latency: a word accepted at edge k gives `valid_out`=1 with the first byte in the cycle after edge k.
- The second byte is presented the cycle after the first byte's transfer edge.
- With `ready_out` held at 1, the two bytes appear on consecutive cycles.
- `ready_out` low stalls in the current state with no byte loss or duplication.
- Throughput without the macro: one word per 3 cycles at best (accept, byte 1, byte 2).
- Throughput with the macro: one word per 2 cycles, giving a 100% output duty cycle.
- No combinational path from `valid_in` or `data_in` to `valid_out` or `data_out`.

## Configuration
- `WIDTH_16TO8_PIPE_EN`:
  - Defined: `ready_in` = `rst_n` && (state==`IDLE` || (state==`SECOND` && `ready_out`)). A word accepted in the same cycle as the second byte's transfer goes straight to `FIRST`, so words stream back-to-back.
  - Undefined: `ready_in` = `rst_n` && (state==`IDLE`). `ready_in` depends on registered state only, with no `ready_out`-to-`ready_in` combinational path.

## Structure
- Shared package `width_conv_pkg`, also used by the 8-to-16 packer, holds:
  - enum `conv_state_e` {`IDLE`, `FIRST`, `SECOND`}
  - localparam `BYTE_W`=8
  - localparam `WORD_W`=16
- Single module with no sub-module. The half-select mux is an inline function in the package.

## Test plan
- Reset, `MSB_FIRST`=1, `ready_out`=1, send 0x45AB → after 1 cycle `data_out` 0x45 then 0xAB on consecutive cycles; `ready_in` returns to 1 afterwards.
- `MSB_FIRST`=0, send 0xF238 → `data_out` 0x38 then 0xF2.
- Send 0x1234, hold `ready_out`=0 for 3 cycles during `FIRST` → 0x12 stays stable with `valid_out`=1; after release, 0x12 then 0x34; no duplicates.
- `WIDTH_16TO8_PIPE_EN` defined, `valid_in` held with 0x1234 then 0x5678, `ready_out`=1 → bytes 12, 34, 56, 78 on four consecutive cycles.
- Assert `rst_n`=0 while in `SECOND` with 0xABCD (0xAB already sent) → next cycle `valid_out`=0, `data_out`=0, 0xCD never emitted.
- Loopback into the 8-to-16 packer with random words and random `ready_out` → reassembled words equal the input sequence, in order.
